// File: rtl/datamem_hs_if.sv
// Request/response bus of the wait-state data memory.
// The master drives a request and the memory returns a one-cycle rvalid pulse.
interface datamem_hs_if #(
  parameter int DW = 32
);
  logic            req;
  logic            W;
  logic [31:0]     Adr;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] be;
  logic            ready;
  logic            rvalid;
  logic [DW-1:0]   C;
  logic            err;

  modport master (
    output req, W, Adr, data, be,
    input  ready, rvalid, C, err
  );

  modport slave (
    input  req, W, Adr, data, be,
    output ready, rvalid, C, err
  );
endinterface

// File: rtl/datamem_hs.sv
// Byte-addressed, byte-enabled data memory behind a request/response handshake.
// Each transaction is accepted in IDLE, waits WAIT_CYC cycles, and then responds for one cycle.
module datamem_hs #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  datamem_hs_if.slave  bus
);
  localparam int          NB         = DW / 8;
  localparam int          OFS        = (NB > 1) ? $clog2(NB) : 0;
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);
  localparam logic [32:0] LIMIT      = 33'(DEPTH * NB);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            accept;
  logic            enter_resp;

  // Address decode of the live request.
  logic            adr_bad;
  logic [AW-1:0]   adr_idx;

  // Transaction captured on accept.
  logic            w_q;
  logic            bad_q;
  logic [AW-1:0]   idx_q;
  logic [DW-1:0]   data_q;
  logic [NB-1:0]   be_q;

  // Transaction as seen by the commit edge.
  logic            cur_w;
  logic            cur_bad;
  logic [AW-1:0]   cur_idx;
  logic [DW-1:0]   cur_data;
  logic [NB-1:0]   cur_be;

  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   mem [DEPTH];

  // The comparison is one bit wider than Adr so DEPTH*NB = 2**32 still works.
  assign adr_bad = (|(bus.Adr & ALIGN_MASK)) || ({1'b0, bus.Adr} >= LIMIT);
  assign adr_idx = bus.Adr[OFS +: AW];

  assign accept     = (state == S_IDLE) && bus.req;
  assign enter_resp = (state_nx == S_RESP);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (bus.req) begin
          if (WAIT_CYC == 0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= 1'b0;
      bad_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else if (accept) begin
      w_q    <= bus.W;
      bad_q  <= adr_bad;
      idx_q  <= adr_idx;
      data_q <= bus.data;
      be_q   <= bus.be;
    end
  end

  // With zero wait states the commit edge is the accept edge, so the live request is used.
  always_comb begin
    cur_w    = w_q;
    cur_bad  = bad_q;
    cur_idx  = idx_q;
    cur_data = data_q;
    cur_be   = be_q;
    if (state == S_IDLE) begin
      cur_w    = bus.W;
      cur_bad  = adr_bad;
      cur_idx  = adr_idx;
      cur_data = bus.data;
      cur_be   = bus.be;
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and start undefined, leaving a plain RAM.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_w && !cur_bad) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
        end
      end
    end
  end

  // Read data lives only for the RESP cycle, so C is zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (enter_resp && !cur_w && !cur_bad) begin
      rdata_q <= mem[cur_idx];
    end else begin
      rdata_q <= '0;
    end
  end

  assign bus.ready  = (state == S_IDLE);
  assign bus.rvalid = (state == S_RESP);
  assign bus.err    = (state == S_RESP) && bad_q;
  assign bus.C      = rdata_q;

endmodule
